alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream stage of the 4-bit ALU. Accepts operand A, operand B and an opcode as three
//  successive nibbles over a valid/ready input port and drives them, registered, onto the
//  ALU's a/b/op inputs. Captures the ALU's combinational c/co one cycle later and holds the
//  result on a valid/ready output port until it is consumed.
// PARAMETERS
//  WIDTH  4  operand/result width; must match the ALU data width
//  OPW    3  opcode width; must match the ALU op width
// PORTS
//  clk        in   1      single clock; all state updates on posedge clk
//  rst        in   1      reset, synchronous, active-high
//  in_valid   in   1      in_data holds a valid nibble
//  in_data    in   WIDTH  operand A, then B, then opcode (opcode = in_data[OPW-1:0])
//  in_ready   out  1      sequencer accepts in_data this cycle
//  alu_a      out  WIDTH  registered operand A to the ALU
//  alu_b      out  WIDTH  registered operand B to the ALU
//  alu_op     out  OPW    registered opcode to the ALU
//  alu_c      in   WIDTH  ALU result, combinational from alu_a/alu_b/alu_op
//  alu_co     in   1      ALU carry out; meaningful only for ADD
//  res_valid  out  1      res_c/res_co/res_err hold a result
//  res_ready  in   1      consumer takes the result this cycle
//  res_c      out  WIDTH  captured result
//  res_co     out  1      captured carry
//  res_err    out  1      opcode was illegal (3'b101..3'b111)
// BEHAVIOUR
//  - Reset: state=LD_A. All outputs 0, except in_ready=1 (combinational from state LD_A).
//    Reset takes effect from any state and discards any partial operation.
//  - FSM states: LD_A -> LD_B -> LD_OP -> ISSUE -> RESULT -> LD_A.
//  - A transfer occurs when in_valid & in_ready. LD_A/LD_B/LD_OP advance only on a transfer.
//  - in_ready = 1 in LD_A, LD_B and LD_OP; 0 in ISSUE and RESULT.
//  - Register updates on a transfer: in LD_A, alu_a<=in_data; in LD_B, alu_b<=in_data;
//    in LD_OP, alu_op<=in_data[OPW-1:0]. Unused upper bits are ignored.
//  - alu_a/alu_b/alu_op change only on their own transfer. They stay stable through ISSUE
//    and RESULT.
//  - ISSUE lasts exactly 1 cycle. At its end: res_c<=alu_c, res_co<=alu_co if op==3'b100
//    else 0, res_err<=0, res_valid<=1.
//  - Illegal op (>3'b100): ISSUE instead captures res_c<=0, res_co<=0, res_err<=1, so no
//    stale ALU value is ever forwarded.
//  - Latency: 1 cycle from the opcode transfer to ISSUE, so res_valid rises 2 cycles after
//    the opcode transfer.
//  - RESULT: res_* are held unchanged while res_ready=0. When res_ready=1: res_valid<=0 and
//    the FSM leaves RESULT; res_c/res_co/res_err keep their last value.
//  - Back-pressure: no new input is accepted until the result is consumed. There is no
//    input skid; in_valid while in_ready=0 is ignored.
// CONFIGURATION
//  ACC_CHAIN_EN defined:
//    - On leaving RESULT: alu_a<=res_c, then go to LD_B (the result becomes operand A).
//    - The sequence restarts at LD_A only after reset.
//  ACC_CHAIN_EN undefined: RESULT -> LD_A and alu_a is reloaded from input.
// STRUCTURE
//  Package alu_seq_pkg holds:
//    - opcode constants OP_NOT=3'b000, OP_AND=3'b001, OP_OR=3'b010, OP_XOR=3'b011,
//      OP_ADD=3'b100, and OP_LAST=OP_ADD for the legality check;
//    - state encoding LD_A, LD_B, LD_OP, ISSUE, RESULT.
//  No sub-module: one FSM plus registers. my_ALU is instantiated beside this block at the
//  top level, not inside it.
// TESTING
//  1. Feed 0101,0011,op 100 -> alu_a=0101, alu_b=0011; res_c=1000, res_co=0, res_err=0;
//     res_valid rises 2 cycles after the op transfer.
//  2. Feed 1111,0001,op 100 -> res_c=0000, res_co=1.
//  3. Feed 1100,1010,op 001 -> res_c=1000, res_co=0 (co forced 0 even if alu_co stale=1).
//  4. Feed op 110 -> res_err=1, res_c=0000, res_co=0.
//  5. Hold res_ready=0 for 5 cycles with in_valid=1 -> res_* constant, in_ready=0,
//     no input consumed; then res_ready=1 -> res_valid=0 next cycle, in_ready=1.
//  6. Assert rst in LD_B after A=0111 loaded -> next cycle state LD_A, alu_a=0, outputs 0.
//  7. ACC_CHAIN_EN defined: after test 1, feed 0001, op 100 -> res_c=1001, A not re-requested.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode and state definitions for the ALU operand sequencer
//
// Contents:
//   OP_NOT..OP_ADD  opcode values understood by the downstream 4-bit ALU
//   OP_LAST         highest legal opcode; anything above is reported as an error
//   state_t         sequencer FSM states
package alu_seq_pkg;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_LAST = OP_ADD;

  typedef enum logic [2:0] {
    LD_A   = 3'd0,
    LD_B   = 3'd1,
    LD_OP  = 3'd2,
    ISSUE  = 3'd3,
    RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - nibble input, ALU drive/capture and result handshake bundle
//
// Signals:
//   in_valid/in_data/in_ready        operand A, operand B, opcode nibbles (in order)
//   alu_a/alu_b/alu_op               registered operands driven to the ALU
//   alu_c/alu_co                     combinational ALU result returned to the sequencer
//   res_valid/res_ready              result handshake
//   res_c/res_co/res_err             captured result, carry and illegal-opcode flag
// Modports:
//   slave   the sequencer side
//   master  the environment side (input producer, ALU, result consumer)
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_c;
  logic             alu_co;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_c;
  logic             res_co;
  logic             res_err;

  modport slave (
    input  in_valid, in_data, alu_c, alu_co, res_ready,
    output in_ready, alu_a, alu_b, alu_op, res_valid, res_c, res_co, res_err
  );

  modport master (
    output in_valid, in_data, alu_c, alu_co, res_ready,
    input  in_ready, alu_a, alu_b, alu_op, res_valid, res_c, res_co, res_err
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - collects A/B/opcode nibbles, drives the ALU, holds its result
//
// Loads operand A, operand B and an opcode from successive input transfers, holds
// them on alu_a/alu_b/alu_op, samples the ALU's combinational c/co one cycle after
// the opcode lands and presents the result until the consumer takes it.
//
// Ports:
//   clk   in   clock, all state changes on its rising edge
//   rst   in   synchronous active-high reset; returns to LD_A, clears all outputs
//   bus   slave modport of alu_op_sequencer_if (input nibbles, ALU drive/capture,
//              result handshake)
//
// Build option:
//   ACC_CHAIN_EN  when defined, a consumed result is loaded back as operand A and
//                 the next sequence starts by requesting operand B only.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);

  state_t state;
  state_t state_n;
  logic   op_illegal;
  logic   op_is_add;

  assign op_illegal = (bus.alu_op > OPW'(OP_LAST));
  assign op_is_add  = (bus.alu_op == OPW'(OP_ADD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LD_A;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    bus.in_ready = 1'b0;
    case (state)
      LD_A: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = LD_B;
      end
      LD_B: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = LD_OP;
      end
      LD_OP: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = ISSUE;
      end
      ISSUE: begin
        state_n = RESULT;
      end
      RESULT: begin
        if (bus.res_ready) begin
`ifdef ACC_CHAIN_EN
          state_n = LD_B;
`else
          state_n = LD_A;
`endif
        end
      end
      default: begin
        state_n = LD_A;
      end
    endcase
  end

  // in_ready is high in exactly the three load states, so in those states a
  // transfer reduces to in_valid alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_op    <= '0;
      bus.res_valid <= 1'b0;
      bus.res_c     <= '0;
      bus.res_co    <= 1'b0;
      bus.res_err   <= 1'b0;
    end else begin
      case (state)
        LD_A: begin
          if (bus.in_valid) bus.alu_a <= bus.in_data;
        end
        LD_B: begin
          if (bus.in_valid) bus.alu_b <= bus.in_data;
        end
        LD_OP: begin
          if (bus.in_valid) bus.alu_op <= bus.in_data[OPW-1:0];
        end
        ISSUE: begin
          // An illegal opcode returns a clean zero result instead of whatever the
          // ALU happens to drive; carry is only meaningful for ADD.
          bus.res_valid <= 1'b1;
          bus.res_err   <= op_illegal;
          bus.res_c     <= op_illegal ? '0 : bus.alu_c;
          bus.res_co    <= op_is_add & bus.alu_co;
        end
        RESULT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
`ifdef ACC_CHAIN_EN
            bus.alu_a     <= bus.res_c;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
